// File: rtl/ddr_frame_arbiter.sv
// Shares one DDR2 local port between four camera write channels and the VGA read channel.
// Fixed-length bursts; each channel ping-pongs between two frame buffers.
module ddr_arb_wr_chan #(
    parameter int PTR_W       = 10,
    parameter int FRAME_WORDS = 768,
    parameter int BURST_LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             active,
    input  logic             done,
    output logic [PTR_W-1:0] ptr,
    output logic             bank
);
    logic pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= '0;
            bank <= 1'b0;
            pend <= 1'b0;
        end else if (done) begin
            // A frame start seen during the burst replaces the normal increment
            if (pend || frame_start) begin
                ptr  <= '0;
                bank <= ~bank;
            end else if (ptr == PTR_W'(FRAME_WORDS - BURST_LEN)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_W'(BURST_LEN);
            end
            pend <= 1'b0;
        end else if (frame_start) begin
            if (active) begin
                pend <= 1'b1;
            end else begin
                ptr  <= '0;
                bank <= ~bank;
            end
        end
    end
endmodule

module ddr_frame_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 24,
    parameter int SIZE_W      = 3,
    parameter int BURST_LEN   = 4,
    parameter int FRAME_WORDS = 768
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ddr_init_done,
    input  logic [3:0]          wr_req,
    input  logic [3:0]          wr_frame_start,
    input  logic [4*DATA_W-1:0] wr_data,
    output logic [3:0]          wr_fifo_rden,
    input  logic                rd_req,
    input  logic                rd_frame_start,
    input  logic [1:0]          rd_sel,
    output logic                rd_fifo_wren,
    output logic [DATA_W-1:0]   rd_fifo_data,
    input  logic                local_ready,
    input  logic                local_rdata_valid,
    input  logic [DATA_W-1:0]   local_rdata,
    output logic [ADDR_W-1:0]   local_address,
    output logic [SIZE_W-1:0]   local_size,
    output logic                local_burstbegin,
    output logic                local_write_req,
    output logic                local_read_req,
    output logic [DATA_W-1:0]   local_wdata,
    output logic                busy
);
    localparam int PTR_W = $clog2(FRAME_WORDS);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT} state_t;

    state_t                  state, state_n;
    logic [1:0]              last_grant, pick, scan_idx;
    logic                    found;
    logic [CNT_W-1:0]        beat_cnt;
    logic                    beat_last, wr_acc, rd_acc, wr_done, rd_done;
    logic [3:0][PTR_W-1:0]   wr_ptr;
    logic [3:0]              wr_bank, wr_active;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    rd_bank, rd_pend;
    logic [1:0]              rd_ch;

    function automatic logic [ADDR_W-1:0] region_addr(input logic [1:0] ch, input logic bank,
                                                      input logic [PTR_W-1:0] ptr);
        return ADDR_W'({ch, bank}) * ADDR_W'(FRAME_WORDS) + ADDR_W'(ptr);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_ch
        assign wr_active[c] = (state == WR_BURST) && (last_grant == 2'(c));
        ddr_arb_wr_chan #(.PTR_W(PTR_W), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN)) u_chan (
            .clk         (clk),
            .rst         (rst),
            .frame_start (wr_frame_start[c]),
            .active      (wr_active[c]),
            .done        (wr_active[c] & wr_done),
            .ptr         (wr_ptr[c]),
            .bank        (wr_bank[c])
        );
    end

    assign beat_last = (beat_cnt == CNT_W'(BURST_LEN - 1));
    assign wr_acc    = (state == WR_BURST) && local_ready;
    assign rd_acc    = (state == RD_WAIT) && local_rdata_valid;
    assign wr_done   = wr_acc && beat_last;
    assign rd_done   = rd_acc && beat_last;
    assign busy      = (state != IDLE);

    // Round-robin scan starting just after the last granted channel
    always_comb begin
        found    = 1'b0;
        pick     = last_grant;
        scan_idx = last_grant;
        for (int i = 1; i <= 4; i++) begin
            scan_idx = last_grant + 2'(i);
            if (!found && wr_req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (ddr_init_done) begin
                if (rd_req)     state_n = RD_CMD;
                else if (found) state_n = WR_BURST;
            end
            WR_BURST: if (wr_done)     state_n = IDLE;
            RD_CMD:   if (local_ready) state_n = RD_WAIT;
            RD_WAIT:  if (rd_done)     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        local_write_req  = 1'b0;
        local_read_req   = 1'b0;
        local_burstbegin = 1'b0;
        local_size       = '0;
        local_address    = '0;
        local_wdata      = '0;
        wr_fifo_rden     = '0;
        rd_fifo_wren     = 1'b0;
        rd_fifo_data     = '0;
        case (state)
            WR_BURST: begin
                local_write_req            = 1'b1;
                local_size                 = SIZE_W'(BURST_LEN);
                local_burstbegin           = (beat_cnt == '0);
                local_address              = region_addr(last_grant, wr_bank[last_grant], wr_ptr[last_grant]);
                local_wdata                = wr_data[last_grant*DATA_W +: DATA_W];
                wr_fifo_rden[last_grant]   = local_ready;
            end
            RD_CMD: begin
                local_read_req   = 1'b1;
                local_burstbegin = 1'b1;
                local_size       = SIZE_W'(BURST_LEN);
                local_address    = region_addr(rd_ch, rd_bank, rd_ptr);
            end
            RD_WAIT: begin
                rd_fifo_wren = local_rdata_valid;
                rd_fifo_data = local_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            beat_cnt   <= '0;
            rd_ptr     <= '0;
            rd_bank    <= 1'b1;
            rd_ch      <= 2'd0;
            rd_pend    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == WR_BURST)
                last_grant <= pick;
            if (wr_acc || rd_acc)
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            // Display switches to the other bank of the selected channel (last finished frame)
            if (rd_done) begin
                if (rd_pend || rd_frame_start) begin
                    rd_ptr  <= '0;
                    rd_ch   <= rd_sel;
                    rd_bank <= ~wr_bank[rd_sel];
                end else if (rd_ptr == PTR_W'(FRAME_WORDS - BURST_LEN)) begin
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + PTR_W'(BURST_LEN);
                end
                rd_pend <= 1'b0;
            end else if (rd_frame_start) begin
                if (state == RD_CMD || state == RD_WAIT) begin
                    rd_pend <= 1'b1;
                end else begin
                    rd_ptr  <= '0;
                    rd_ch   <= rd_sel;
                    rd_bank <= ~wr_bank[rd_sel];
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Directed bench for ddr_frame_arbiter: vector table for round-robin, hand sequences for corners.
module tb_ddr_frame_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         ddr_init_done;
    logic [3:0]   wr_req, wr_frame_start, wr_fifo_rden;
    logic [127:0] wr_data;
    logic         rd_req, rd_frame_start, rd_fifo_wren;
    logic [1:0]   rd_sel;
    logic [31:0]  rd_fifo_data, local_rdata, local_wdata;
    logic         local_ready, local_rdata_valid;
    logic [23:0]  local_address;
    logic [2:0]   local_size;
    logic         local_burstbegin, local_write_req, local_read_req, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr_frame_arbiter dut (
        .clk(clk), .rst(rst), .ddr_init_done(ddr_init_done),
        .wr_req(wr_req), .wr_frame_start(wr_frame_start), .wr_data(wr_data),
        .wr_fifo_rden(wr_fifo_rden), .rd_req(rd_req), .rd_frame_start(rd_frame_start),
        .rd_sel(rd_sel), .rd_fifo_wren(rd_fifo_wren), .rd_fifo_data(rd_fifo_data),
        .local_ready(local_ready), .local_rdata_valid(local_rdata_valid),
        .local_rdata(local_rdata), .local_address(local_address), .local_size(local_size),
        .local_burstbegin(local_burstbegin), .local_write_req(local_write_req),
        .local_read_req(local_read_req), .local_wdata(local_wdata), .busy(busy)
    );

    typedef struct {
        logic [3:0]  wr_req;
        logic        rdy;
        logic        e_wreq;
        logic        e_bb;
        logic [3:0]  e_rden;
        logic [23:0] e_addr;
        logic        e_busy;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] wd(input int c);
        return 32'hD0D0_0000 + 32'(c);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req = '0; wr_frame_start = '0; rd_req = 1'b0; rd_frame_start = 1'b0; rd_sel = 2'd0;
        local_ready = 1'b0; local_rdata_valid = 1'b0; local_rdata = '0;
        #3;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Waits (bounded) for a write burst, checks its address, runs its 4 beats with
    // local_ready=1, pulsing wr_frame_start[0] on the beats flagged in fs_mask.
    task automatic wr_burst(input logic [23:0] exp_addr, input logic [3:0] fs_mask, input string nm);
        int n = 0;
        while (!local_write_req && n < 20) begin tick(); n++; end
        if (!local_write_req) begin
            checks++; errors++;
            $display("FAIL %s timeout actual=no_write_req expected=write_req", nm);
            return;
        end
        chk(nm, 32'(local_address), 32'(exp_addr));
        for (int b = 0; b < 4; b++) begin
            wr_frame_start = fs_mask[b] ? 4'b0001 : 4'b0000;
            tick();
        end
        wr_frame_start = '0;
    endtask

    initial begin
        int bad, pulses;
        int chs[5];
        logic [23:0] ads[5];
        logic rp[7];
        logic vp[5];
        int k;

        wr_data = {wd(3), wd(2), wd(1), wd(0)};
        ddr_init_done = 1'b0;

        chs = '{0, 1, 2, 3, 0};
        ads = '{24'd0, 24'd1536, 24'd3072, 24'd4608, 24'd4};
        for (int b = 0; b < 5; b++) begin
            vq.push_back('{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 24'd0, 1'b0, 32'd0});
            for (int t = 0; t < 4; t++)
                vq.push_back('{4'b1111, 1'b1, 1'b1, (t == 0), 4'b0001 << chs[b], ads[b], 1'b1, wd(chs[b])});
        end

        // Reset state
        rst = 1'b1;
        wr_req = '0; wr_frame_start = '0; rd_req = 1'b0; rd_frame_start = 1'b0; rd_sel = 2'd0;
        local_ready = 1'b0; local_rdata_valid = 1'b0; local_rdata = '0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wreq", 32'(local_write_req), 0);
        chk("rst_addr", 32'(local_address), 0);
        do_reset();

        // Init gating
        wr_req = 4'b1111; local_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (local_write_req !== 1'b0 || busy !== 1'b0 || wr_fifo_rden !== 4'b0) bad++;
            tick();
        end
        chk("init_gate_cycles_bad", 32'(bad), 0);

        // Round-robin vector table
        ddr_init_done = 1'b1;
        foreach (vq[i]) begin
            wr_req = vq[i].wr_req; local_ready = vq[i].rdy;
            #1;
            chk($sformatf("rr%0d_wreq", i), 32'(local_write_req), 32'(vq[i].e_wreq));
            chk($sformatf("rr%0d_bb", i), 32'(local_burstbegin), 32'(vq[i].e_bb));
            chk($sformatf("rr%0d_rden", i), 32'(wr_fifo_rden), 32'(vq[i].e_rden));
            chk($sformatf("rr%0d_addr", i), 32'(local_address), 32'(vq[i].e_addr));
            chk($sformatf("rr%0d_busy", i), 32'(busy), 32'(vq[i].e_busy));
            chk($sformatf("rr%0d_wdata", i), local_wdata, vq[i].e_wdata);
            if (vq[i].e_wreq) chk($sformatf("rr%0d_size", i), 32'(local_size), 4);
            tick();
        end

        // Backpressure on ch0 (ptr now 8)
        wr_req = 4'b0001; local_ready = 1'b1;
        tick();
        rp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            local_ready = rp[i];
            #1;
            chk($sformatf("bp%0d_rden", i), 32'(wr_fifo_rden), {31'd0, rp[i]});
            chk($sformatf("bp%0d_addr", i), 32'(local_address), 8);
            chk($sformatf("bp%0d_wreq", i), 32'(local_write_req), 1);
            if (i < 2) chk($sformatf("bp%0d_bb", i), 32'(local_burstbegin), (i == 0) ? 1 : 0);
            if (wr_fifo_rden[0]) pulses++;
            if (i == 6) wr_req = 4'b0000;
            tick();
        end
        chk("bp_pulses", 32'(pulses), 4);
        chk("bp_end_wreq", 32'(local_write_req), 0);

        // Read priority, held command, data pass-through
        do_reset();
        rd_req = 1'b1; wr_req = 4'b0001; local_ready = 1'b0;
        local_rdata_valid = 1'b1; local_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rdv_ignored_idle", 32'(rd_fifo_wren), 0);
        local_rdata_valid = 1'b0;
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rcmd%0d_rreq", i), 32'(local_read_req), 1);
            chk($sformatf("rcmd%0d_wreq", i), 32'(local_write_req), 0);
            chk($sformatf("rcmd%0d_addr", i), 32'(local_address), 768);
            chk($sformatf("rcmd%0d_bb", i), 32'(local_burstbegin), 1);
            tick();
        end
        local_ready = 1'b1;
        #1;
        chk("rcmd_acc_rreq", 32'(local_read_req), 1);
        tick();
        chk("rwait_rreq", 32'(local_read_req), 0);
        vp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        k = 0;
        for (int i = 0; i < 5; i++) begin
            local_rdata_valid = vp[i];
            local_rdata = vp[i] ? 32'hA5A5_0000 + 32'(k) : 32'h1111_1111;
            #1;
            chk($sformatf("rd%0d_wren", i), 32'(rd_fifo_wren), {31'd0, vp[i]});
            if (vp[i]) begin
                chk($sformatf("rd%0d_data", i), rd_fifo_data, 32'hA5A5_0000 + 32'(k));
                k++;
            end
            tick();
        end
        local_rdata_valid = 1'b0;
        chk("rd_done_busy", 32'(busy), 0);
        tick();
        chk("wr_after_rd", 32'(local_write_req), 1);
        wr_req = '0;

        // Frame buffers: wrap, deferred bank toggle, read bank select
        do_reset();
        local_ready = 1'b1; wr_req = 4'b0001;
        for (int b = 0; b < 192; b++) wr_burst(24'(4 * b), 4'b0000, "wrap_seq");
        wr_burst(24'd0, 4'b0000, "wrap_to_0");
        wr_burst(24'd4, 4'b0010, "fs_midburst");
        wr_burst(24'd768, 4'b0000, "bank1_addr");
        wr_req = '0; rd_frame_start = 1'b1; rd_sel = 2'd0;
        tick();
        rd_frame_start = 1'b0; rd_req = 1'b1;
        tick();
        chk("rfs_rreq", 32'(local_read_req), 1);
        chk("rfs_addr", 32'(local_address), 0);
        rd_req = 1'b0;
        tick();
        local_rdata_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        local_rdata_valid = 1'b0;
        chk("rfs_done_busy", 32'(busy), 0);
        wr_req = 4'b0001;
        wr_burst(24'd772, 4'b0101, "fs_absorb");
        wr_burst(24'd0, 4'b0000, "fs_single_toggle");
        wr_req = '0; wr_frame_start = 4'b0010;
        tick();
        wr_frame_start = '0; wr_req = 4'b0010;
        wr_burst(24'd2304, 4'b0000, "fs_idle_ch1");
        wr_req = '0;

        // Reset in the middle of a ch2 burst
        do_reset();
        local_ready = 1'b1; wr_req = 4'b0100;
        tick();
        chk("rst_mid_addr", 32'(local_address), 3072);
        chk("rst_mid_wdata", local_wdata, wd(2));
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_wreq", 32'(local_write_req), 0);
        chk("rst_async_rden", 32'(wr_fifo_rden), 0);
        chk("rst_async_addr", 32'(local_address), 0);
        chk("rst_async_wdata", local_wdata, 0);
        chk("rst_async_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0; wr_req = 4'b1111;
        #1;
        chk("rst_rel_busy", 32'(busy), 0);
        tick();
        chk("rst_rel_wreq", 32'(local_write_req), 1);
        chk("rst_rel_rden", 32'(wr_fifo_rden), 32'b0001);
        chk("rst_rel_addr", 32'(local_address), 0);
        wr_req = '0;
        for (int i = 0; i < 5; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
